// File: rtl/sb_config_loader.sv
// sb_config_loader
//   Master end of the switch-box configuration scan chain. A parallel bitstream
//   word is captured on start and shifted LSB-first into the chain head. When
//   VERIFY is set, the same word is shifted a second time, and the bits that
//   emerge at the chain tail are compared against it.
//
// Ports
//   prog_clk   in   config clock, all state on posedge
//   prog_rst   in   async active-high reset
//   start      in   begin a load (only looked at in IDLE)
//   abort      in   sync abort back to IDLE, wins over everything else
//   bitstream  in   config word, captured into the shadow register on start
//   chain_out  in   prog_out of the chain tail
//   prog_in    out  serial data to chain head (registered)
//   prog_en    out  chain shift enable (registered)
//   busy       out  high while shifting (LOAD/VERIFY)
//   done       out  one-cycle pulse on successful completion
//   verify_ok  out  last verify had zero mismatches; held until next start
//   err_cnt    out  mismatch count of last verify, saturating
//
// state  | meaning
// IDLE   | chain idle, waiting for start
// LOAD   | shifting the word into the chain
// VFY    | re-shifting the word and comparing tail readback
// FIN    | one-cycle completion, done pulse

module sb_config_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 6,
    parameter bit VERIFY    = 1'b1
) (
    input  logic                 prog_clk,
    input  logic                 prog_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] bitstream,
    input  logic                 chain_out,
    output logic                 prog_in,
    output logic                 prog_en,
    output logic                 busy,
    output logic                 done,
    output logic                 verify_ok,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        VFY  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_t               state, state_nxt;
    logic [CHAIN_LEN-1:0] shadow, shadow_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [CNT_W-1:0]     err_nxt;
    logic                 prog_in_nxt, prog_en_nxt, verify_ok_nxt;
    logic                 last_bit, mismatch;

    assign last_bit = (cnt == LAST_BIT);
    // prog_in holds the bit being sent this cycle, which is also the bit
    // expected back from the tail during the verify pass.
    assign mismatch = (state == VFY) && (chain_out != prog_in);

    assign busy = (state == LOAD) || (state == VFY);
    assign done = (state == FIN);

    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        cnt_nxt       = cnt;
        err_nxt       = err_cnt;
        verify_ok_nxt = verify_ok;
        prog_en_nxt   = 1'b0;
        prog_in_nxt   = 1'b0;

        if (abort) begin
            state_nxt     = IDLE;
            verify_ok_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // shadow[0] always holds the bit that goes out next
                        shadow_nxt    = {bitstream[0], bitstream[CHAIN_LEN-1:1]};
                        cnt_nxt       = '0;
                        err_nxt       = '0;
                        verify_ok_nxt = 1'b0;
                        prog_en_nxt   = 1'b1;
                        prog_in_nxt   = bitstream[0];
                        state_nxt     = LOAD;
                    end
                end
                LOAD, VFY: begin
                    if (mismatch && (err_cnt != ERR_MAX)) begin
                        err_nxt = err_cnt + CNT_W'(1);
                    end
                    if (last_bit) begin
                        cnt_nxt = '0;
                        if ((state == LOAD) && VERIFY) begin
                            state_nxt = VFY;
                        end else begin
                            state_nxt     = FIN;
                            verify_ok_nxt = (err_nxt == '0);
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    // Rotation keeps the whole word so the verify pass resends it
                    // with no gap after the load pass.
                    if (state_nxt != FIN) begin
                        prog_en_nxt = 1'b1;
                        prog_in_nxt = shadow[0];
                        shadow_nxt  = {shadow[0], shadow[CHAIN_LEN-1:1]};
                    end
                end
                FIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            state     <= IDLE;
            shadow    <= '0;
            cnt       <= '0;
            err_cnt   <= '0;
            verify_ok <= 1'b0;
            prog_en   <= 1'b0;
            prog_in   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shadow    <= shadow_nxt;
            cnt       <= cnt_nxt;
            err_cnt   <= err_nxt;
            verify_ok <= verify_ok_nxt;
            prog_en   <= prog_en_nxt;
            prog_in   <= prog_in_nxt;
        end
    end

endmodule
